cnn3d_conv_stream: RTL and testbench
====================================

// Module: cnn3d_conv_stream
// PURPOSE
//  Parametrised 3D convolution engine (valid-only, stride 1, no padding): NxNxN signed image, NUM_FILTERS MxMxM kernels.
//  Image/kernels loaded at run time through a write port (no file init); results streamed out with valid/ready backpressure.
//  One MAC per cycle; sits between feature-map buffer and next CNN layer / pooling stage.
// PARAMETERS
//  DATA_W      8   signed width of image and kernel samples
//  OUT_W       16  signed width of streamed result (saturated)
//  IMG_SIZE    6   image edge N (N^3 samples)
//  FILT_SIZE   3   kernel edge M (M^3 taps per kernel), M<=N
//  NUM_FILTERS 3   number of kernels; output count = NUM_FILTERS*(N-M+1)^3
// PORTS
//  clk        in  1        rising-edge clock
//  reset      in  1        asynchronous, active-high reset
//  wr_en      in  1        write strobe for image/kernel memory
//  wr_sel     in  1        0 = image memory, 1 = kernel memory
//  wr_addr    in  AW       flat address: img d*N*N+r*N+c; kernel f*M^3+d*M*M+r*M+c
//  wr_data    in  DATA_W   sample written
//  start      in  1        1-cycle pulse: begin full convolution
//  busy       out 1        high from cycle after accepted start until done
//  done       out 1        1-cycle pulse after last result accepted
//  out_valid  out 1        result available
//  out_ready  in  1        downstream accepts result
//  out_data   out OUT_W    result value
//  out_filt   out FW       kernel index of current result
//  out_last   out 1        high with final result of whole run
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, out_valid, out_last=0; out_data, out_filt=0; all counters 0. Memories not cleared.
//  AW=$clog2(max(N^3, NUM_FILTERS*M^3)); FW=max(1,$clog2(NUM_FILTERS)).
//  FSM: IDLE -start-> CLEAR -> MAC (M^3 cycles) -> EMIT -out_ready-> CLEAR (next position) or DONE -> IDLE.
//  CLEAR: accumulator <= 0, tap counters <= 0. MAC: acc += img[pos+tap]*kern[f][tap]; tap order col, row, depth.
//  Accumulator ACC_W = 2*DATA_W + $clog2(M^3)+1 bits; never overflows internally.
//  EMIT: out_valid=1; out_data = acc saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; data/filt/last stable until out_ready.
//  Output order: filter outermost, then out depth, row, col (col fastest). out_last on filter NF-1, position (R-1,R-1,R-1), R=N-M+1.
//  Latency per result: 1 + M^3 cycles to out_valid; first result valid M^3+2 cycles after start pulse.
//  DONE: done=1 for exactly one cycle, busy drops same edge; next start accepted the following cycle.
//  start while busy: ignored. wr_en while busy: ignored (memories frozen during run). wr_addr out of range: ignored.
//  wr_en and start in same IDLE cycle: write completes, run starts next cycle using new value.
//  out_ready held low: engine stalls in EMIT indefinitely, no result lost or duplicated.
//  reset mid-run: immediate return to IDLE, outputs per reset values; partial results discarded.
// CONFIGURATION
//  CNN3D_RELU_EN defined: out_data = max(0, saturated result) (fused ReLU, negatives emitted as 0).
//  CNN3D_RELU_EN undefined: out_data = saturated signed result, negatives passed through.
//  Timing and handshake identical in both builds.
// TESTING
//  N=4,M=3,NF=2, image all 1, kernels all 1 -> 16 results each 27, out_filt 0 x8 then 1 x8, out_last only on 16th.
//  Kernel 0 delta at tap (1,1,1), image[i]=i -> result(d,r,c)=(d+1)*16+(r+1)*4+(c+1), e.g. first=21.
//  Image all 127, kernel all 127 (M=3), OUT_W=16 -> 435483 saturates to 32767; all -128 x 127 -> -32768 (0 with RELU_EN).
//  out_ready low 20 cycles on 3rd result -> out_valid/out_data held stable; total results still exactly 16, done once.
//  start pulsed and wr_en asserted mid-run -> no restart, memory unchanged, results match golden model.
//  reset asserted during MAC of 5th result -> busy/out_valid 0 next edge; fresh start yields full correct 16-result run.

Source files
------------

// File: rtl/cnn3d_conv_stream.sv
`default_nettype none
// ============================================================================
// Module   : cnn3d_conv_stream
// Purpose  : 3D valid-only convolution engine, stride 1, no padding.
//            NxNxN signed image with NUM_FILTERS MxMxM signed kernels, both
//            loaded through a write port. Performs one multiply-accumulate per
//            cycle and streams saturated results over a valid/ready handshake.
//            Output order: filter outermost, then depth, row, col (col fastest).
// Ports    : clk, reset (async, active high)
//            wr_en/wr_sel/wr_addr/wr_data : image (sel=0) / kernel (sel=1) load
//            start, busy, done            : run control
//            out_valid/out_ready/out_data/out_filt/out_last : result stream
// Config   : CNN3D_RELU_EN defined   -> negative results emitted as 0
//            CNN3D_RELU_EN undefined -> saturated signed results passed through
// Revision : 1.0 - initial release
// ============================================================================
module cnn3d_conv_stream #(
  parameter int DATA_W      = 8,
  parameter int OUT_W       = 16,
  parameter int IMG_SIZE    = 6,
  parameter int FILT_SIZE   = 3,
  parameter int NUM_FILTERS = 3,
  localparam int IMG_WORDS  = IMG_SIZE * IMG_SIZE * IMG_SIZE,
  localparam int KERN_WORDS = NUM_FILTERS * FILT_SIZE * FILT_SIZE * FILT_SIZE,
  localparam int AW = $clog2((IMG_WORDS > KERN_WORDS) ? IMG_WORDS : KERN_WORDS),
  localparam int FW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [FW-1:0]     out_filt,
  output logic              out_last
);

  localparam int M3    = FILT_SIZE * FILT_SIZE * FILT_SIZE;
  localparam int R     = IMG_SIZE - FILT_SIZE + 1;
  localparam int ACC_W = 2 * DATA_W + $clog2(M3) + 1;
  localparam int IAW   = $clog2(IMG_WORDS);
  localparam int KAW   = $clog2(KERN_WORDS);
  localparam int CW    = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;

  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW-1:0] C_MLAST = CW'(FILT_SIZE - 1);
  localparam logic [CW-1:0] C_RLAST = CW'(R - 1);
  localparam logic [FW-1:0] C_FLAST = FW'(NUM_FILTERS - 1);
  localparam logic [FW-1:0] C_FONE  = FW'(1);
  // One extra bit so a full power-of-two memory still compares correctly.
  localparam logic [AW:0]   C_IMG_LIM  = (AW+1)'(IMG_WORDS);
  localparam logic [AW:0]   C_KERN_LIM = (AW+1)'(KERN_WORDS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_MAC   = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] img_mem  [0:IMG_WORDS-1];
  logic [DATA_W-1:0] kern_mem [0:KERN_WORDS-1];

  logic [CW-1:0] tap_c, tap_r, tap_d;
  logic [CW-1:0] pos_c, pos_r, pos_d;
  logic [FW-1:0] filt;

  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    acc_nxt;
  logic signed [2*DATA_W-1:0] img_ext, kern_ext, prod;
  logic [IAW-1:0]             img_idx;
  logic [KAW-1:0]             kern_idx;
  logic [OUT_W-1:0]           sat_val;
  logic [OUT_W-1:0]           result;

  logic tap_last, pos_last, filt_last, run_last;

  // --------------------------------------------------------------------------
  // Position / tap bookkeeping
  // --------------------------------------------------------------------------
  assign tap_last  = (tap_c == C_MLAST) && (tap_r == C_MLAST) && (tap_d == C_MLAST);
  assign pos_last  = (pos_c == C_RLAST) && (pos_r == C_RLAST) && (pos_d == C_RLAST);
  assign filt_last = (filt == C_FLAST);
  assign run_last  = pos_last && filt_last;

  // pos+tap never exceeds N-1, so the sums fit the counter width.
  assign img_idx  = IAW'(pos_d + tap_d) * IAW'(IMG_SIZE * IMG_SIZE)
                  + IAW'(pos_r + tap_r) * IAW'(IMG_SIZE)
                  + IAW'(pos_c + tap_c);
  assign kern_idx = KAW'(filt)  * KAW'(M3)
                  + KAW'(tap_d) * KAW'(FILT_SIZE * FILT_SIZE)
                  + KAW'(tap_r) * KAW'(FILT_SIZE)
                  + KAW'(tap_c);

  // --------------------------------------------------------------------------
  // MAC datapath
  // --------------------------------------------------------------------------
  assign img_ext  = (2*DATA_W)'($signed(img_mem[img_idx]));
  assign kern_ext = (2*DATA_W)'($signed(kern_mem[kern_idx]));
  assign prod     = img_ext * kern_ext;
  assign acc_nxt  = acc + ACC_W'(prod);

  generate
    if (ACC_W > OUT_W) begin : g_sat
      localparam logic signed [ACC_W-1:0] SAT_HI =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
      localparam logic signed [ACC_W-1:0] SAT_LO =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
      always_comb begin
        sat_val = acc_nxt[OUT_W-1:0];
        if (acc_nxt > SAT_HI) begin
          sat_val = SAT_HI[OUT_W-1:0];
        end else if (acc_nxt < SAT_LO) begin
          sat_val = SAT_LO[OUT_W-1:0];
        end
      end
    end else begin : g_nosat
      assign sat_val = OUT_W'(acc_nxt);
    end
  endgenerate

`ifdef CNN3D_RELU_EN
  assign result = sat_val[OUT_W-1] ? '0 : sat_val;
`else
  assign result = sat_val;
`endif

  // --------------------------------------------------------------------------
  // Memories: writable only while idle; out-of-range addresses dropped.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_en && (state == S_IDLE)) begin
      if (!wr_sel && ({1'b0, wr_addr} < C_IMG_LIM)) begin
        img_mem[wr_addr[IAW-1:0]] <= wr_data;
      end
      if (wr_sel && ({1'b0, wr_addr} < C_KERN_LIM)) begin
        kern_mem[wr_addr[KAW-1:0]] <= wr_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        busy      = 1'b1;
        state_nxt = S_MAC;
      end
      S_MAC: begin
        busy = 1'b1;
        if (tap_last) state_nxt = S_EMIT;
      end
      S_EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = run_last ? S_DONE : S_CLEAR;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Counters, accumulator and registered result
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      tap_c    <= '0;
      tap_r    <= '0;
      tap_d    <= '0;
      pos_c    <= '0;
      pos_r    <= '0;
      pos_d    <= '0;
      filt     <= '0;
      out_data <= '0;
      out_filt <= '0;
      out_last <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pos_c <= '0;
            pos_r <= '0;
            pos_d <= '0;
            filt  <= '0;
          end
        end
        S_CLEAR: begin
          acc   <= '0;
          tap_c <= '0;
          tap_r <= '0;
          tap_d <= '0;
        end
        S_MAC: begin
          acc <= acc_nxt;
          if (tap_c == C_MLAST) begin
            tap_c <= '0;
            if (tap_r == C_MLAST) begin
              tap_r <= '0;
              tap_d <= tap_d + C_ONE;
            end else begin
              tap_r <= tap_r + C_ONE;
            end
          end else begin
            tap_c <= tap_c + C_ONE;
          end
          // Final tap: capture the finished sum so it holds through EMIT.
          if (tap_last) begin
            out_data <= result;
            out_filt <= filt;
            out_last <= run_last;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            out_last <= 1'b0;
            if (pos_c == C_RLAST) begin
              pos_c <= '0;
              if (pos_r == C_RLAST) begin
                pos_r <= '0;
                if (pos_d == C_RLAST) begin
                  pos_d <= '0;
                  filt  <= filt_last ? '0 : (filt + C_FONE);
                end else begin
                  pos_d <= pos_d + C_ONE;
                end
              end else begin
                pos_r <= pos_r + C_ONE;
              end
            end else begin
              pos_c <= pos_c + C_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cnn3d_conv_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnn3d_conv_stream
// Purpose  : Self-checking bench for cnn3d_conv_stream (N=4, M=3, NF=2).
//            Expected results come from a direct triple-loop convolution over
//            bench-held image/kernel arrays.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnn3d_conv_stream;

  localparam int N    = 4;
  localparam int M    = 3;
  localparam int NF   = 2;
  localparam int R    = N - M + 1;
  localparam int M3   = M * M * M;
  localparam int NRES = NF * R * R * R;

  logic        clk, reset, wr_en, wr_sel, start, out_ready;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy, done, out_valid, out_last;
  logic [15:0] out_data;
  logic [0:0]  out_filt;

  cnn3d_conv_stream #(
    .DATA_W(8), .OUT_W(16), .IMG_SIZE(N), .FILT_SIZE(M), .NUM_FILTERS(NF)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_addr(wr_addr), .wr_data(wr_data), .start(start), .busy(busy),
    .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_filt(out_filt), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int img  [N*N*N];
  int kern [NF*M3];
  int exp_data [NRES];
  int exp_filt [NRES];
  int exp_last [NRES];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Reference: plain convolution, clamp, optional ReLU, in output order.
  task automatic build_model();
    int idx = 0;
    for (int f = 0; f < NF; f++)
      for (int d = 0; d < R; d++)
        for (int r = 0; r < R; r++)
          for (int c = 0; c < R; c++) begin
            longint s = 0;
            for (int kd = 0; kd < M; kd++)
              for (int kr = 0; kr < M; kr++)
                for (int kc = 0; kc < M; kc++)
                  s += img[(d+kd)*N*N + (r+kr)*N + (c+kc)] * kern[f*M3 + kd*M*M + kr*M + kc];
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
`ifdef CNN3D_RELU_EN
            if (s < 0) s = 0;
`endif
            exp_data[idx] = int'(s);
            exp_filt[idx] = f;
            exp_last[idx] = (idx == NRES - 1) ? 1 : 0;
            idx++;
          end
  endtask

  task automatic wr(input int sel, input int addr, input int data);
    wr_en   = 1'b1;
    wr_sel  = sel[0];
    wr_addr = 6'(addr);
    wr_data = 8'(data);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < N*N*N; i++) wr(0, i, img[i]);
    for (int i = 0; i < NF*M3; i++) wr(1, i, kern[i]);
    wr(1, 60, 55);  // beyond kernel memory, must be dropped
  endtask

  // mode: 0 ready always, 1 random ready, 2 stall 20 cycles on 3rd result.
  // rst_at >= 0: async reset during MAC of result number rst_at+1, then return.
  task automatic run(input int mode, input bit disturb, input int rst_at,
                     input int sw_addr, input int sw_val);
    int edges = 0, nres = 0, ndone = 0, first = -1, stall = 0, mac_wait = 0, tail = 0;
    bit fin = 0;
    out_ready = 1'b1;
    start     = 1'b1;
    if (sw_addr >= 0) begin
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 6'(sw_addr); wr_data = 8'(sw_val);
    end
    @(posedge clk); #1;
    start = 1'b0;
    wr_en = 1'b0;
    edges = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (out_valid && first < 0) begin
        first = edges;
        check("first_latency", first, M3 + 2);
        check("busy_in_run", busy, 1);
      end
      if (rst_at >= 0 && nres == rst_at && !out_valid) begin
        mac_wait++;
        if (mac_wait == 10) begin
          reset = 1'b1;
          #1;
          check("rst_busy", busy, 0);
          check("rst_valid", out_valid, 0);
          check("rst_data", out_data, 0);
          check("rst_last", out_last, 0);
          @(posedge clk); #1;
          reset = 1'b0;
          return;
        end
      end
      if (done) begin
        ndone++;
        check("busy_at_done", busy, 0);
        fin = 1;
      end
      if (out_valid && out_ready) begin
        if (nres < NRES) begin
          check("data", longint'($signed(out_data)), exp_data[nres]);
          check("filt", out_filt, exp_filt[nres]);
          check("last", out_last, exp_last[nres]);
        end else begin
          check("extra_result", nres, NRES - 1);
        end
        nres++;
      end
      if (mode == 2 && out_valid && !out_ready && nres == 2) begin
        stall++;
        check("stall_data", longint'($signed(out_data)), exp_data[2]);
        check("stall_filt", out_filt, exp_filt[2]);
      end
      if (fin) tail++;
      if (tail == 6) break;
      @(posedge clk); #1;
      edges++;
      case (mode)
        1:       out_ready = 1'($urandom_range(0, 1));
        2:       out_ready = (nres == 2 && stall < 20) ? 1'b0 : 1'b1;
        default: out_ready = 1'b1;
      endcase
      if (disturb && edges == 100) begin
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_sel  = 1'($urandom_range(0, 1));
        wr_addr = 6'($urandom_range(0, 53));
        wr_data = 8'($urandom);
      end else begin
        start = 1'b0;
        wr_en = 1'b0;
      end
    end
    check("result_count", nres, NRES);
    check("done_count", ndone, 1);
    if (mode == 2) check("stall_cycles", stall, 20);
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < N*N*N; i++) img[i] = int'($urandom_range(0, 255)) - 128;
    for (int i = 0; i < NF*M3; i++) kern[i] = int'($urandom_range(0, 255)) - 128;
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0;
    wr_data = '0; start = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_valid", out_valid, 0);
    check("reset_last", out_last, 0);
    check("reset_data", out_data, 0);
    check("reset_filt", out_filt, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // All ones: every result 27.
    for (int i = 0; i < N*N*N; i++) img[i] = 1;
    for (int i = 0; i < NF*M3; i++) kern[i] = 1;
    load_all();
    build_model();
    run(0, 0, -1, -1, 0);

    // Centre-tap delta on kernel 0, ramp image; random kernel 1.
    for (int i = 0; i < N*N*N; i++) img[i] = i;
    for (int i = 0; i < M3; i++) kern[i] = (i == 13) ? 1 : 0;
    for (int i = M3; i < NF*M3; i++) kern[i] = int'($urandom_range(0, 255)) - 128;
    load_all();
    build_model();
    run(1, 0, -1, -1, 0);

    // Positive and negative saturation.
    for (int i = 0; i < N*N*N; i++) img[i] = 127;
    for (int i = 0; i < NF*M3; i++) kern[i] = 127;
    load_all();
    build_model();
    run(0, 0, -1, -1, 0);
    for (int i = 0; i < N*N*N; i++) img[i] = -128;
    load_all();
    build_model();
    run(0, 0, -1, -1, 0);

    // Random data, stall on 3rd result, image write in the start cycle.
    randomize_mem();
    load_all();
    img[5] = (img[5] == 100) ? -100 : 100;
    build_model();
    run(2, 0, -1, 5, img[5]);

    // Start and write pulsed mid-run must be ignored; rerun to confirm memory.
    run(1, 1, -1, -1, 0);
    run(0, 0, -1, -1, 0);

    // Reset during the 5th result's MAC, then a fresh full run.
    randomize_mem();
    load_all();
    build_model();
    run(0, 0, 4, -1, 0);
    @(negedge clk);
    check("post_rst_valid", out_valid, 0);
    check("post_rst_busy", busy, 0);
    @(posedge clk); #1;
    run(1, 0, -1, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
